// File: rtl/adc_capture_fmt.sv
// rtl/adc_capture_fmt.sv - multi-channel ADC capture, lane alignment and format pipeline
module adc_capture_fmt #(
    parameter  int CH         = 2,
    parameter  int W          = 8,
    parameter  int DEPTH      = 8,
    parameter  int OUT_STAGES = 3,
    localparam int DW         = $clog2(DEPTH)
) (
    input  logic             QCLK,
    input  logic             RESET_N,
    input  logic [CH*W-1:0]  DIN,
    input  logic             DIN_VLD,
    input  logic [CH-1:0]    DIN_OR,
    input  logic             CFG_LD,
    input  logic [1:0]       MODE,
    input  logic [W-1:0]     OFFSET,
    input  logic [CH*DW-1:0] DLY,
    input  logic             STICKY_CLR,
    output logic [CH*W-1:0]  DOUT,
    output logic [CH-1:0]    DOUT_VLD,
    output logic [CH-1:0]    DOUT_OR,
    output logic [CH-1:0]    SAT_STICKY,
    output logic             FLUSHING
);

    localparam int            LOAD       = DEPTH + OUT_STAGES + 1;
    localparam int            CW         = $clog2(LOAD + 1);
    localparam logic [CW-1:0] LOAD_V     = CW'(LOAD);
    localparam logic [W-1:0]  LEGACY_ADD = W'((1 << (W - 1)) + 1);
    localparam logic [W-1:0]  SAT_MAX    = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0]  SAT_MIN    = {1'b1, {(W - 1){1'b0}}};

    typedef struct packed {
        logic [W-1:0] data;
        logic         vld;
        logic         ovr;
    } smp_t;

    typedef enum logic {ST_RUN, ST_FLUSH} st_t;

    // Entry 0 of each line is the input capture register, so DLY indexes the line directly.
    smp_t             line_q [CH][DEPTH];
    smp_t             line_d [CH][DEPTH];
    smp_t             fmt_q  [CH];
    smp_t             fmt_d  [CH];
    smp_t             out_q  [CH][OUT_STAGES];
    smp_t             out_d  [CH][OUT_STAGES];
    logic [CH-1:0]    fmt_sat_q, fmt_sat_d;
    logic [1:0]       mode_q, mode_d;
    logic [W-1:0]     offset_q, offset_d;
    logic [CH*DW-1:0] dly_q, dly_d;
    logic [CH-1:0]    sticky_q, sticky_d;
    st_t              st_q, st_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    smp_t             tap  [CH];
    logic [W-1:0]     conv [CH];
    logic [W:0]       sum  [CH];

    always_comb begin
        mode_d   = mode_q;
        offset_d = offset_q;
        dly_d    = dly_q;
        if (CFG_LD) begin
            mode_d   = MODE;
            offset_d = OFFSET;
            dly_d    = DLY;
        end
    end

    always_comb begin
        fmt_sat_d = '0;
        for (int c = 0; c < CH; c++) begin
            line_d[c][0] = {DIN[c*W +: W], DIN_VLD, DIN_OR[c]};
            for (int k = 1; k < DEPTH; k++) begin
                line_d[c][k] = line_q[c][k-1];
            end

            tap[c]  = line_q[c][dly_q[c*DW +: DW]];
            conv[c] = (mode_q == 2'd2) ? tap[c].data + LEGACY_ADD
                                       : {~tap[c].data[W-1], tap[c].data[W-2:0]};
            sum[c]  = {conv[c][W-1], conv[c]} + {offset_q[W-1], offset_q};

            fmt_d[c] = tap[c];
            if (mode_q != 2'd0) begin
                // Sign bits of the W+1 bit sum disagree only when the result left the W-bit range.
                if (sum[c][W] != sum[c][W-1]) begin
                    fmt_d[c].data = sum[c][W] ? SAT_MIN : SAT_MAX;
                    fmt_sat_d[c]  = tap[c].vld;
                end else begin
                    fmt_d[c].data = sum[c][W-1:0];
                end
            end

            out_d[c][0] = fmt_q[c];
            for (int k = 1; k < OUT_STAGES; k++) begin
                out_d[c][k] = out_q[c][k-1];
            end
        end
    end

    // Clear is applied first so a same-cycle set survives it.
    always_comb begin
        sticky_d = STICKY_CLR ? '0 : sticky_q;
        for (int c = 0; c < CH; c++) begin
            sticky_d[c] = sticky_d[c] | fmt_sat_q[c] | (fmt_q[c].vld & fmt_q[c].ovr);
        end
    end

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        case (st_q)
            ST_RUN: begin
                if (CFG_LD) begin
                    st_d  = ST_FLUSH;
                    cnt_d = LOAD_V;
                end
            end
            ST_FLUSH: begin
                if (CFG_LD) begin
                    cnt_d = LOAD_V;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        st_d = ST_RUN;
                    end
                end
            end
            default: begin
                st_d  = ST_RUN;
                cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        DOUT       = '0;
        DOUT_VLD   = '0;
        DOUT_OR    = '0;
        SAT_STICKY = sticky_q;
        FLUSHING   = (st_q == ST_FLUSH);
        for (int c = 0; c < CH; c++) begin
            DOUT[c*W +: W] = out_q[c][OUT_STAGES-1].data;
            DOUT_VLD[c]    = out_q[c][OUT_STAGES-1].vld & (st_q != ST_FLUSH);
            DOUT_OR[c]     = out_q[c][OUT_STAGES-1].ovr;
        end
    end

    always_ff @(posedge QCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    line_q[c][k] <= '0;
                end
                fmt_q[c] <= '0;
                for (int k = 0; k < OUT_STAGES; k++) begin
                    out_q[c][k] <= '0;
                end
            end
            fmt_sat_q <= '0;
            mode_q    <= 2'd2;
            offset_q  <= '0;
            dly_q     <= '0;
            sticky_q  <= '0;
            st_q      <= ST_RUN;
            cnt_q     <= '0;
        end else begin
            line_q    <= line_d;
            fmt_q     <= fmt_d;
            out_q     <= out_d;
            fmt_sat_q <= fmt_sat_d;
            mode_q    <= mode_d;
            offset_q  <= offset_d;
            dly_q     <= dly_d;
            sticky_q  <= sticky_d;
            st_q      <= st_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_adc_capture_fmt.sv
// tb/tb_adc_capture_fmt.sv - self-checking bench for adc_capture_fmt
module tb_adc_capture_fmt;

    localparam int CH         = 2;
    localparam int W          = 8;
    localparam int DEPTH      = 8;
    localparam int OUT_STAGES = 3;
    localparam int DW         = 3;
    localparam int LAT        = OUT_STAGES + 2;
    localparam int NV         = 11;

    logic             QCLK = 1'b0;
    logic             RESET_N;
    logic [CH*W-1:0]  DIN;
    logic             DIN_VLD;
    logic [CH-1:0]    DIN_OR;
    logic             CFG_LD;
    logic [1:0]       MODE;
    logic [W-1:0]     OFFSET;
    logic [CH*DW-1:0] DLY;
    logic             STICKY_CLR;
    logic [CH*W-1:0]  DOUT;
    logic [CH-1:0]    DOUT_VLD;
    logic [CH-1:0]    DOUT_OR;
    logic [CH-1:0]    SAT_STICKY;
    logic             FLUSHING;

    adc_capture_fmt #(.CH(CH), .W(W), .DEPTH(DEPTH), .OUT_STAGES(OUT_STAGES)) dut (
        .QCLK(QCLK), .RESET_N(RESET_N), .DIN(DIN), .DIN_VLD(DIN_VLD), .DIN_OR(DIN_OR),
        .CFG_LD(CFG_LD), .MODE(MODE), .OFFSET(OFFSET), .DLY(DLY), .STICKY_CLR(STICKY_CLR),
        .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .DOUT_OR(DOUT_OR), .SAT_STICKY(SAT_STICKY),
        .FLUSHING(FLUSHING)
    );

    always #5 QCLK = ~QCLK;

    typedef struct {
        int         due;
        int         ch;
        logic [7:0] data;
        logic       vld;
        logic       ovr;
    } exp_t;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] off;
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    exp_t       sbq[$];
    vec_t       vecs[NV];
    int         cyc     = 0;
    int         n_pass  = 0;
    int         n_total = 0;
    logic [1:0] cur_mode;
    logic [7:0] cur_off;
    int         cur_dly[CH];
    logic [7:0] ramp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Integer reference: interpret per mode, add signed offset, clamp. Returns {sat, data}.
    function automatic logic [8:0] model(input logic [1:0] m, input logic [7:0] off, input logic [7:0] d);
        int v;
        int o;
        logic [7:0] r;
        if (m == 2'd0) return {1'b0, d};
        if (m == 2'd2) begin
            v = (int'(d) + 129) % 256;
            if (v >= 128) v = v - 256;
        end else begin
            v = int'(d) - 128;
        end
        o = int'(off);
        if (o >= 128) o = o - 256;
        v = v + o;
        if (v > 127)  return {1'b1, 8'h7F};
        if (v < -128) return {1'b1, 8'h80};
        r = v[7:0];
        return {1'b0, r};
    endfunction

    task automatic tick();
        int i;
        @(posedge QCLK);
        cyc++;
        #1;
        i = 0;
        while (i < sbq.size()) begin
            if (sbq[i].due == cyc) begin
                check($sformatf("dout ch%0d", sbq[i].ch), 32'(DOUT[sbq[i].ch*W +: W]), 32'(sbq[i].data));
                check($sformatf("dout_vld ch%0d", sbq[i].ch), 32'(DOUT_VLD[sbq[i].ch]), 32'(sbq[i].vld));
                check($sformatf("dout_or ch%0d", sbq[i].ch), 32'(DOUT_OR[sbq[i].ch]), 32'(sbq[i].ovr));
                sbq.delete(i);
            end else if (sbq[i].due < cyc) begin
                check("scoreboard stale entry", 32'(sbq[i].due), 32'(cyc));
                sbq.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic drive(input logic [7:0] d0, input logic [7:0] d1, input logic v,
                         input logic [1:0] orb, input bit chk,
                         input bit use_exp = 1'b0, input logic [7:0] exp0 = 8'h00);
        logic [7:0] d;
        logic [8:0] m;
        exp_t       e;
        DIN     = {d1, d0};
        DIN_VLD = v;
        DIN_OR  = orb;
        if (chk) begin
            for (int c = 0; c < CH; c++) begin
                d      = (c == 0) ? d0 : d1;
                m      = model(cur_mode, cur_off, d);
                e.due  = cyc + LAT + cur_dly[c];
                e.ch   = c;
                e.data = (c == 0 && use_exp) ? exp0 : m[7:0];
                e.vld  = v;
                e.ovr  = orb[c];
                sbq.push_back(e);
            end
        end
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'h00, 8'h00, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic cfg(input logic [1:0] m, input logic [7:0] off, input int d0, input int d1, input logic v);
        int cnt;
        int guard;
        bit vld_seen;
        MODE   = m;
        OFFSET = off;
        DLY    = {3'(d1), 3'(d0)};
        CFG_LD = 1'b1;
        drive(ramp, ramp, v, 2'b00, 1'b0);
        ramp++;
        CFG_LD = 1'b0;
        // Scramble the config inputs: only the pulse may load them.
        MODE   = ~m;
        OFFSET = ~off;
        DLY    = '1;
        cur_mode   = m;
        cur_off    = off;
        cur_dly[0] = d0;
        cur_dly[1] = d1;
        cnt      = 0;
        guard    = 0;
        vld_seen = 1'b0;
        while (FLUSHING === 1'b1 && guard < 40) begin
            cnt++;
            guard++;
            if (DOUT_VLD !== 2'b00) vld_seen = 1'b1;
            drive(ramp, ramp, v, 2'b00, 1'b0);
            ramp++;
        end
        check("flush length", 32'(cnt), 32'(DEPTH + OUT_STAGES + 1));
        check("dout_vld during flush", 32'(vld_seen), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        RESET_N = 1'b0; DIN = '0; DIN_VLD = 1'b0; DIN_OR = '0; CFG_LD = 1'b0;
        MODE = 2'd0; OFFSET = '0; DLY = '0; STICKY_CLR = 1'b0;
        ramp = 8'h00; cur_mode = 2'd2; cur_off = 8'h00; cur_dly[0] = 0; cur_dly[1] = 0;

        vecs[0]  = '{2'd2, 8'h00, 8'h7F, 8'h00};
        vecs[1]  = '{2'd2, 8'h00, 8'h00, 8'h81};
        vecs[2]  = '{2'd2, 8'h00, 8'hFF, 8'h80};
        vecs[3]  = '{2'd2, 8'hFD, 8'h7E, 8'hFC};
        vecs[4]  = '{2'd1, 8'h00, 8'h80, 8'h00};
        vecs[5]  = '{2'd1, 8'h00, 8'h00, 8'h80};
        vecs[6]  = '{2'd1, 8'h0A, 8'hFF, 8'h7F};
        vecs[7]  = '{2'd1, 8'h0A, 8'h05, 8'h8F};
        vecs[8]  = '{2'd1, 8'hF6, 8'h00, 8'h80};
        vecs[9]  = '{2'd3, 8'h00, 8'h7F, 8'hFF};
        vecs[10] = '{2'd0, 8'h0A, 8'h3C, 8'h3C};

        repeat (3) tick();
        check("reset dout", 32'(DOUT), 32'd0);
        check("reset dout_vld", 32'(DOUT_VLD), 32'd0);
        check("reset dout_or", 32'(DOUT_OR), 32'd0);
        check("reset sat_sticky", 32'(SAT_STICKY), 32'd0);
        check("reset flushing", 32'(FLUSHING), 32'd0);
        RESET_N = 1'b1;

        // Idle samples first so the scoreboard sees DOUT_VLD low right up to the first result.
        repeat (3) drive(8'h00, 8'h00, 1'b0, 2'b00, 1'b1);
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].mode !== cur_mode || vecs[i].off !== cur_off) begin
                idle(6);
                cfg(vecs[i].mode, vecs[i].off, 0, 0, 1'b0);
            end
            drive(vecs[i].din, vecs[i].din ^ 8'h5A, 1'b1, 2'b00, 1'b1, 1'b1, vecs[i].dout);
        end
        idle(6);

        // Saturation and sticky behaviour.
        cfg(2'd1, 8'h0A, 0, 0, 1'b0);
        STICKY_CLR = 1'b1;
        idle(1);
        STICKY_CLR = 1'b0;
        check("sticky cleared", 32'(SAT_STICKY), 32'd0);
        drive(8'hFF, 8'h00, 1'b1, 2'b00, 1'b1);
        idle(1);
        check("sticky not yet set", 32'(SAT_STICKY), 32'd0);
        idle(1);
        check("sticky set by saturation", 32'(SAT_STICKY), 32'h1);
        STICKY_CLR = 1'b1;
        idle(1);
        STICKY_CLR = 1'b0;
        check("sticky clear 2", 32'(SAT_STICKY), 32'd0);
        drive(8'hFF, 8'h00, 1'b1, 2'b00, 1'b1);
        idle(1);
        STICKY_CLR = 1'b1;
        idle(1);
        STICKY_CLR = 1'b0;
        check("sticky set wins over clear", 32'(SAT_STICKY), 32'h1);
        STICKY_CLR = 1'b1;
        idle(1);
        STICKY_CLR = 1'b0;
        check("sticky lone clear", 32'(SAT_STICKY), 32'd0);
        drive(8'hFF, 8'h00, 1'b0, 2'b01, 1'b1);
        idle(6);
        check("invalid sample no sticky", 32'(SAT_STICKY), 32'd0);

        // Lane alignment: ch1 delayed by 3 extra cycles.
        cfg(2'd0, 8'h00, 0, 3, 1'b1);
        repeat (16) begin
            drive(ramp, ramp, 1'b1, 2'b00, 1'b1);
            ramp++;
        end

        // Over-range on ch1 follows the delayed sample.
        drive(ramp, ramp, 1'b1, 2'b10, 1'b1);
        ramp++;
        repeat (4) begin
            drive(ramp, ramp, 1'b1, 2'b00, 1'b1);
            ramp++;
        end
        check("or sticky not yet set", 32'(SAT_STICKY), 32'd0);
        drive(ramp, ramp, 1'b1, 2'b00, 1'b1);
        ramp++;
        check("or sets sticky ch1", 32'(SAT_STICKY), 32'h2);
        idle(10);

        // Reset mid-stream after loading a non-default mode.
        cfg(2'd1, 8'h05, 0, 0, 1'b1);
        repeat (4) begin
            drive(ramp, ramp, 1'b1, 2'b00, 1'b0);
            ramp++;
        end
        check("dout_vld before reset", 32'(DOUT_VLD), 32'h3);
        RESET_N = 1'b0;
        #1;
        check("midreset dout", 32'(DOUT), 32'd0);
        check("midreset dout_vld", 32'(DOUT_VLD), 32'd0);
        check("midreset dout_or", 32'(DOUT_OR), 32'd0);
        check("midreset sat_sticky", 32'(SAT_STICKY), 32'd0);
        check("midreset flushing", 32'(FLUSHING), 32'd0);
        repeat (2) begin
            drive(ramp, ramp, 1'b1, 2'b00, 1'b0);
            ramp++;
        end
        RESET_N    = 1'b1;
        cur_mode   = 2'd2;
        cur_off    = 8'h00;
        cur_dly[0] = 0;
        cur_dly[1] = 0;
        for (int i = 0; i < 10; i++) begin
            drive(ramp, ramp + 8'h11, 1'b1, 2'b00, 1'b1);
            ramp++;
            if (i < 4) check("dout_vld refill after reset", 32'(DOUT_VLD), 32'd0);
        end
        idle(6);
        check("scoreboard drained", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adc_capture_fmt.md
# adc_capture_fmt

Parametrised multi-channel ADC sample capture and formatting pipeline. It sits directly behind the differential-to-single-ended receivers in the QCLK domain and replaces the fixed 2-lane, 8-bit capture path. It adds:
- per-channel lane-alignment delay
- selectable output number format
- signed offset correction with saturation
- over-range flag alignment
- per-channel valid and sticky status, with a flush sequencer on configuration change

## Interface
- CH, 2, number of ADC channels (lanes)
- W, 8, sample width in bits
- DEPTH, 8, alignment delay-line length; power of 2, ≥2; DW = log2(DEPTH)
- OUT_STAGES, 3, output retiming registers, ≥1
- QCLK  in  1  sample clock; all logic on rising edge
- RESET_N  in  1  asynchronous active-low reset
- DIN  in  CH*W  raw samples; channel c at [c*W +: W]
- DIN_VLD  in  1  samples on DIN valid this cycle
- DIN_OR  in  CH  per-channel ADC over-range bit, same timing as DIN
- CFG_LD  in  1  single-cycle pulse that loads MODE, OFFSET and DLY
- MODE  in  2  0 = raw pass-through; 1 = offset-binary to two's complement (invert MSB); 2 = legacy, add 2^(W-1)+1 modulo 2^W; 3 = same as 1
- OFFSET  in  W  signed two's-complement correction, added in modes 1–3
- DLY  in  CH*DW  per-channel extra delay, 0..DEPTH-1
- STICKY_CLR  in  1  clears SAT_STICKY
- DOUT  out  CH*W  formatted samples
- DOUT_VLD  out  CH  per-channel valid
- DOUT_OR  out  CH  over-range bit aligned to DOUT
- SAT_STICKY  out  CH  set on a saturation event or an aligned over-range
- FLUSHING  out  1  high while the flush counter is nonzero

## Operation
- Reset state:
  - all pipeline registers, DOUT, DOUT_VLD, DOUT_OR, SAT_STICKY and FLUSHING are 0
  - configuration registers: MODE=2, OFFSET=0, every DLY=0
  - flush counter is 0
- Stage 0: register DIN, DIN_VLD (replicated per channel) and DIN_OR.
- Delay line: per channel, a DEPTH-entry shift register of {data, vld, or}. The tap is selected by the channel's DLY register; DLY=0 bypasses the line.
- Format stage, one register:
  - mode 0: output the data unchanged; OFFSET is ignored; no saturation
  - modes 1/2/3: convert per MODE to a signed W-bit value, add OFFSET in W+1 bits, then saturate to [-2^(W-1), 2^(W-1)-1]
- A saturation event is a valid sample that is clipped. It, or a valid sample with the aligned OR bit set, sets SAT_STICKY[c].
- STICKY_CLR clears all SAT_STICKY bits. When a set and the clear occur in the same cycle, set wins.
- Output stages: OUT_STAGES registers carry data, vld and or; the last one drives DOUT, DOUT_VLD and DOUT_OR.
- Flush sequencer, two states:
  - RUN → FLUSH on CFG_LD; the counter loads DEPTH+OUT_STAGES+1
  - FLUSH decrements the counter each cycle and returns to RUN at 0
  - CFG_LD during FLUSH reloads the counter
- While in FLUSH, every DOUT_VLD bit is forced 0. Data still flows and is not zeroed.
- Invalid samples (vld=0) never set SAT_STICKY. DOUT still carries their formatted data.

## Timing
- A sample on DIN at rising edge n appears on DOUT[c] after edge n+1+DLY[c]+OUT_STAGES. With defaults and DLY=0 this is n+4.
- DOUT_VLD and DOUT_OR have exactly the same latency as their data.
- CFG_LD sampled at edge n:
  - the new MODE, OFFSET and DLY are in effect from edge n+1
  - FLUSHING is high from after edge n until the counter expires: DEPTH+OUT_STAGES+1 cycles
- SAT_STICKY asserts one cycle after the format-stage register that saturated. It does not wait for the output stages.
- Reset is asserted asynchronously and released synchronously by the external reset logic. Reset mid-stream drops all in-flight samples; DOUT_VLD stays 0 until new DIN_VLD samples traverse the full latency.
- Throughput is one sample per channel per cycle. There is no backpressure.

## Test plan
- Legacy mode after reset, W=8, DLY=0, DIN_VLD=1:
  - DIN ch0 = 8'h7F, 8'h00, 8'hFF → DOUT ch0 = 8'h00, 8'h81, 8'h80, first result after edge n+4
  - DOUT_VLD rises at n+4
- Mode 1, OFFSET=0:
  - DIN = 8'h80 → DOUT 8'h00; DIN = 8'h00 → DOUT 8'h80
- Saturation:
  - mode 1, OFFSET=+10, DIN=8'hFF → DOUT 8'h7F and SAT_STICKY[0]=1
  - STICKY_CLR asserted in the same cycle as a new saturation → SAT_STICKY stays 1
  - a later lone STICKY_CLR → 0
- Alignment:
  - ramp 0,1,2,… on both channels, CFG_LD with DLY ch0=0, ch1=3
  - FLUSHING high for 12 cycles with DOUT_VLD=00
  - afterwards ch1 values lag ch0 by exactly 3 cycles
- Over-range:
  - DIN_OR[1] pulsed with a valid sample → DOUT_OR[1] high on exactly the cycle that sample reaches DOUT
  - SAT_STICKY[1] set
- Reset mid-stream:
  - drop RESET_N for 2 cycles during a valid ramp → all outputs 0 immediately, MODE back to 2
  - DOUT_VLD returns 4 cycles after DIN_VLD resumes
